simon_sequencer: RTL and testbench

Parametrised game engine for the Genius/Simon memory game: generates a pseudo-random colour sequence, plays it back one step at a time, checks player button presses against it, and grows the sequence by one step per cleared round. It is the successor to the fixed 3-button, 16-step hardcoded-sequence engine. It adds configurable button count, depth and display timing, LFSR sequence generation, press edge detection, input timeout, and win/lose reporting. It sits between the debounced button inputs and the LED/7-segment display drivers.

---
 rtl/simon_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_simon_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequencer.sv
// Simon/Genius game engine.
// It builds a pseudo-random colour sequence from an LFSR and plays it back.
// It then checks the player's button presses and grows the sequence by one
// step for each cleared round. All outputs come straight from flops.
module simon_sequencer #(
    parameter int          N_BTN         = 4,
    parameter int          MAX_LEN       = 16,
    parameter int          STEP_TICKS    = 4,
    parameter int          GAP_TICKS     = 2,
    parameter int          TIMEOUT_TICKS = 1000,
    parameter logic [15:0] SEED          = 16'hACE1,
    localparam int         W             = (N_BTN > 1) ? $clog2(N_BTN) : 1,
    localparam int         LW            = $clog2(MAX_LEN + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [N_BTN-1:0] btn,
    output logic             show_valid,
    output logic [W-1:0]     show_idx,
    output logic             input_ready,
    output logic             press_ok,
    output logic [LW-1:0]    level,
    output logic             win,
    output logic             lose
);

    localparam int TW    = $clog2(TIMEOUT_TICKS + 1);
    localparam int TMAX  = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
    localparam int TKW   = $clog2(TMAX + 1);
    localparam int DEPTH = 1 << LW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPEND,
        ST_SHOW_ON,
        ST_SHOW_GAP,
        ST_INPUT,
        ST_WIN,
        ST_LOSE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [N_BTN-1:0]   btn_q, btn_d;
    logic [LW-1:0]      level_q, level_d;
    logic [LW-1:0]      idx_q, idx_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [TKW-1:0]     tick_q, tick_d;
    logic               show_valid_q, show_valid_d;
    logic [W-1:0]       show_idx_q, show_idx_d;
    logic               input_ready_q, input_ready_d;
    logic               press_ok_q, press_ok_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;

    // The sequence store is deliberately never cleared; only entries below level are ever read.
    logic [W-1:0]       seq_mem [DEPTH];
    logic               seq_we;

    logic [W-1:0]       raw_colour;
    logic [W-1:0]       colour;
    logic [N_BTN-1:0]   press_edge;
    logic [N_BTN-1:0]   want_onehot;
    logic               last_step;

    // Next-state logic: the FSM, its counters, the LFSR and the registered outputs.
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        tick_d        = tick_q;
        win_d         = win_q;
        lose_d        = lose_q;
        press_ok_d    = 1'b0;
        seq_we        = 1'b0;
        lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        btn_d         = btn;

        raw_colour    = lfsr_q[W-1:0];
        colour        = ({1'b0, raw_colour} >= (W+1)'(N_BTN)) ? raw_colour - W'(N_BTN) : raw_colour;
        press_edge    = btn & ~btn_q;
        want_onehot   = N_BTN'(1) << seq_mem[idx_q];
        last_step     = (idx_q == level_q - LW'(1));

        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    state_d = ST_APPEND;
                    level_d = '0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                end
            end
            ST_APPEND: begin
                seq_we  = 1'b1;
                level_d = level_q + LW'(1);
                idx_d   = '0;
                tick_d  = '0;
                state_d = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (tick_q == TKW'(STEP_TICKS - 1)) begin
                    tick_d  = '0;
                    state_d = ST_SHOW_GAP;
                end else begin
                    tick_d  = tick_q + TKW'(1);
                end
            end
            ST_SHOW_GAP: begin
                if (tick_q == TKW'(GAP_TICKS - 1)) begin
                    tick_d = '0;
                    if (last_step) begin
                        idx_d   = '0;
                        timer_d = '0;
                        state_d = ST_INPUT;
                    end else begin
                        idx_d   = idx_q + LW'(1);
                        state_d = ST_SHOW_ON;
                    end
                end else begin
                    tick_d = tick_q + TKW'(1);
                end
            end
            ST_INPUT: begin
                if (|press_edge) begin
                    if (press_edge == want_onehot) begin
                        press_ok_d = 1'b1;
                        timer_d    = '0;
                        if (last_step) begin
                            if (level_q == LW'(MAX_LEN)) begin
                                win_d   = 1'b1;
                                state_d = ST_WIN;
                            end else begin
                                state_d = ST_APPEND;
                            end
                        end else begin
                            idx_d = idx_q + LW'(1);
                        end
                    end else begin
                        lose_d  = 1'b1;
                        state_d = ST_LOSE;
                    end
                end else if (timer_q == TW'(TIMEOUT_TICKS - 1)) begin
                    lose_d  = 1'b1;
                    state_d = ST_LOSE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the next state so they line up with state_q.
        // APPEND writes the entry that the first SHOW_ON reads, so that entry is bypassed.
        show_valid_d  = (state_d == ST_SHOW_ON);
        input_ready_d = (state_d == ST_INPUT);
        show_idx_d    = '0;
        if (show_valid_d) begin
            show_idx_d = (seq_we && (idx_d == level_q)) ? colour : seq_mem[idx_d];
        end
    end

    // Main state register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lfsr_q        <= SEED;
            btn_q         <= '0;
            level_q       <= '0;
            idx_q         <= '0;
            timer_q       <= '0;
            tick_q        <= '0;
            show_valid_q  <= 1'b0;
            show_idx_q    <= '0;
            input_ready_q <= 1'b0;
            press_ok_q    <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            btn_q         <= btn_d;
            level_q       <= level_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            tick_q        <= tick_d;
            show_valid_q  <= show_valid_d;
            show_idx_q    <= show_idx_d;
            input_ready_q <= input_ready_d;
            press_ok_q    <= press_ok_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
        end
    end

    // The sequence store takes one new colour per APPEND. A reset in that cycle blocks the write.
    always_ff @(posedge clock) begin
        if (seq_we && !reset) begin
            seq_mem[level_q] <= colour;
        end
    end

    assign show_valid  = show_valid_q;
    assign show_idx    = show_idx_q;
    assign input_ready = input_ready_q;
    assign press_ok    = press_ok_q;
    assign level       = level_q;
    assign win         = win_q;
    assign lose        = lose_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed self-checking bench for simon_sequencer.
// It uses a small game with 4 buttons and a maximum length of 3.
// Expected colours come from a model of the 16-bit LFSR. The model is
// sampled in the cycle the engine spends in APPEND.
module tb_simon_sequencer;

    localparam int          N_BTN   = 4;
    localparam int          MAX_LEN = 3;
    localparam int          STEP    = 3;
    localparam int          GAP     = 2;
    localparam int          TMO     = 20;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] btn   = 4'b0000;
    logic       showValid;
    logic [1:0] showIdx;
    logic       inputReady;
    logic       pressOk;
    logic [1:0] level;
    logic       win;
    logic       lose;

    int          checks     = 0;
    int          failures   = 0;
    int          pressCount = 0;
    int          expSeq [MAX_LEN];
    logic [15:0] modelLfsr;

    simon_sequencer #(
        .N_BTN        (N_BTN),
        .MAX_LEN      (MAX_LEN),
        .STEP_TICKS   (STEP),
        .GAP_TICKS    (GAP),
        .TIMEOUT_TICKS(TMO),
        .SEED         (SEED)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .btn        (btn),
        .show_valid (showValid),
        .show_idx   (showIdx),
        .input_ready(inputReady),
        .press_ok   (pressOk),
        .level      (level),
        .win        (win),
        .lose       (lose)
    );

    // Free-running clock with a 10-unit period.
    always #5 clock = ~clock;

    // Reference LFSR: Fibonacci, taps 16,14,13,11, shifting on every non-reset edge.
    always @(posedge clock) begin
        if (reset) modelLfsr <= SEED;
        else       modelLfsr <= {modelLfsr[14:0], modelLfsr[15] ^ modelLfsr[13] ^ modelLfsr[12] ^ modelLfsr[10]};
    end

    function automatic int colourOf(input logic [15:0] l);
        int c;
        c = int'(l[1:0]);
        if (c >= N_BTN) c = c - N_BTN;
        return c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [3:0] b);
        start = st;
        btn   = b;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_show_valid"},  int'(showValid),  0);
        checkOutput({tag, "_show_idx"},    int'(showIdx),    0);
        checkOutput({tag, "_input_ready"}, int'(inputReady), 0);
        checkOutput({tag, "_press_ok"},    int'(pressOk),    0);
        checkOutput({tag, "_level"},       int'(level),      0);
        checkOutput({tag, "_win"},         int'(win),        0);
        checkOutput({tag, "_lose"},        int'(lose),       0);
    endtask

    // Pulse start for one cycle; the following cycle is APPEND, whose LFSR value is the first colour.
    task automatic startGame();
        applyStimulus(1'b1, 4'b0000);
        tick();
        expSeq[0] = colourOf(modelLfsr);
        checkOutput("start_level", int'(level), 0);
        checkOutput("start_show",  int'(showValid), 0);
        checkOutput("start_win",   int'(win), 0);
        checkOutput("start_lose",  int'(lose), 0);
        start = 1'b0;
    endtask

    // Called in the APPEND cycle; walks the whole display and ends in the first INPUT cycle.
    task automatic watchRound(input int len, input logic holdStart);
        start = holdStart;
        for (int s = 0; s < len; s++) begin
            for (int t = 0; t < STEP; t++) begin
                tick();
                checkOutput($sformatf("r%0d_s%0d_on_valid", len, s), int'(showValid), 1);
                checkOutput($sformatf("r%0d_s%0d_on_idx", len, s),   int'(showIdx),   expSeq[s]);
                checkOutput($sformatf("r%0d_s%0d_on_level", len, s), int'(level),     len);
                checkOutput($sformatf("r%0d_s%0d_on_ready", len, s), int'(inputReady), 0);
            end
            for (int t = 0; t < GAP; t++) begin
                tick();
                checkOutput($sformatf("r%0d_s%0d_gap_valid", len, s), int'(showValid), 0);
                checkOutput($sformatf("r%0d_s%0d_gap_idx", len, s),   int'(showIdx),   0);
                checkOutput($sformatf("r%0d_s%0d_gap_ready", len, s), int'(inputReady), 0);
            end
        end
        tick();
        checkOutput($sformatf("r%0d_input_ready", len), int'(inputReady), 1);
        checkOutput($sformatf("r%0d_input_valid", len), int'(showValid),  0);
    endtask

    // Replays the recorded colours; the last press lands in APPEND (or WIN at MAX_LEN).
    task automatic playRound(input int len);
        pressCount = 0;
        for (int i = 0; i < len; i++) begin
            applyStimulus(1'b0, 4'(1) << expSeq[i]);
            tick();
            checkOutput($sformatf("r%0d_p%0d_press_ok", len, i), int'(pressOk), 1);
            if (pressOk) pressCount++;
            if (i == len - 1) begin
                checkOutput($sformatf("r%0d_p%0d_ready_drop", len, i), int'(inputReady), 0);
                if (len < MAX_LEN) expSeq[len] = colourOf(modelLfsr);
                applyStimulus(1'b0, 4'b0000);
            end else begin
                applyStimulus(1'b0, 4'b0000);
                tick();
                checkOutput($sformatf("r%0d_p%0d_pulse_end", len, i), int'(pressOk),    0);
                checkOutput($sformatf("r%0d_p%0d_ready", len, i),     int'(inputReady), 1);
            end
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        reset = 1'b0;
        checkReset("reset");

        // Full game cleared at MAX_LEN
        startGame();
        watchRound(1, 1'b0);
        playRound(1);
        watchRound(2, 1'b0);
        playRound(2);
        watchRound(3, 1'b0);
        playRound(3);
        checkOutput("r3_presses", pressCount, 3);
        checkOutput("win_set",    int'(win), 1);
        checkOutput("win_ready",  int'(inputReady), 0);
        checkOutput("win_level",  int'(level), 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("win_held",       int'(win), 1);
            checkOutput("win_held_level", int'(level), 3);
            checkOutput("win_held_ready", int'(inputReady), 0);
            checkOutput("win_held_show",  int'(showValid), 0);
        end

        // Wrong colour in round 2
        startGame();
        watchRound(1, 1'b0);
        playRound(1);
        watchRound(2, 1'b0);
        applyStimulus(1'b0, 4'(1) << ((expSeq[0] + 1) % 4));
        tick();
        checkOutput("wrong_lose",  int'(lose), 1);
        checkOutput("wrong_level", int'(level), 2);
        checkOutput("wrong_ok",    int'(pressOk), 0);
        checkOutput("wrong_ready", int'(inputReady), 0);
        applyStimulus(1'b0, 4'b0000);
        tick();
        checkOutput("lose_held",       int'(lose), 1);
        checkOutput("lose_held_level", int'(level), 2);

        // Restart from LOSE, then let the round time out
        startGame();
        watchRound(1, 1'b0);
        for (int i = 1; i < TMO; i++) begin
            tick();
            checkOutput($sformatf("tmo_wait%0d_lose", i),  int'(lose), 0);
            checkOutput($sformatf("tmo_wait%0d_ready", i), int'(inputReady), 1);
        end
        tick();
        checkOutput("tmo_lose",  int'(lose), 1);
        checkOutput("tmo_ready", int'(inputReady), 0);

        // A correct press in the last allowed cycle restarts the timer
        startGame();
        watchRound(1, 1'b0);
        playRound(1);
        watchRound(2, 1'b0);
        for (int i = 1; i < TMO; i++) begin
            tick();
            checkOutput($sformatf("late_wait%0d_lose", i), int'(lose), 0);
        end
        applyStimulus(1'b0, 4'(1) << expSeq[0]);
        tick();
        checkOutput("late_press_ok", int'(pressOk), 1);
        checkOutput("late_lose",     int'(lose), 0);
        checkOutput("late_ready",    int'(inputReady), 1);
        applyStimulus(1'b0, 4'b0000);
        for (int i = 1; i < TMO; i++) begin
            tick();
            checkOutput($sformatf("restart%0d_lose", i),  int'(lose), 0);
            checkOutput($sformatf("restart%0d_level", i), int'(level), 2);
        end
        tick();
        checkOutput("restart_tmo_lose", int'(lose), 1);

        // Two buttons rising together
        startGame();
        watchRound(1, 1'b0);
        applyStimulus(1'b0, 4'b0011);
        tick();
        checkOutput("double_lose", int'(lose), 1);
        checkOutput("double_ok",   int'(pressOk), 0);
        applyStimulus(1'b0, 4'b0000);

        // Button held from the display into INPUT is not a press
        startGame();
        applyStimulus(1'b0, 4'(1) << expSeq[0]);
        watchRound(1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("held_ok",    int'(pressOk), 0);
            checkOutput("held_lose",  int'(lose), 0);
            checkOutput("held_ready", int'(inputReady), 1);
        end
        applyStimulus(1'b0, 4'b0000);
        tick();
        checkOutput("release_ok",    int'(pressOk), 0);
        checkOutput("release_ready", int'(inputReady), 1);
        applyStimulus(1'b0, 4'(1) << expSeq[0]);
        tick();
        checkOutput("repress_ok",    int'(pressOk), 1);
        checkOutput("repress_ready", int'(inputReady), 0);
        expSeq[1] = colourOf(modelLfsr);
        applyStimulus(1'b0, 4'b0000);

        // start held through SHOW and INPUT is ignored
        watchRound(2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("ign_ready", int'(inputReady), 1);
            checkOutput("ign_level", int'(level), 2);
            checkOutput("ign_show",  int'(showValid), 0);
        end
        start = 1'b0;
        playRound(2);

        // Reset in the middle of SHOW_ON
        tick();
        checkOutput("mid_show_valid", int'(showValid), 1);
        checkOutput("mid_show_idx",   int'(showIdx), expSeq[0]);
        checkOutput("mid_show_level", int'(level), 3);
        tick();
        reset = 1'b1;
        tick();
        checkReset("midreset");
        reset = 1'b0;
        tick();
        checkReset("post_reset");
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("idle_show",  int'(showValid), 0);
            checkOutput("idle_level", int'(level), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
